// File: rtl/univ_reg_n.sv
// N-bit universal register: preset/load/shift/rotate/count with complementary outputs and wrap flag (parity output with UNIV_REG_PARITY_EN).
// Latency: one clk edge from inputs to Q/co; Qnot/sol/sor are combinational from Q.
// Backpressure: none; en low freezes Q, clr low clears asynchronously.
module univ_reg_n #(
  parameter int          N       = 8,
  parameter logic [N-1:0] PRE_VAL = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         pre,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] D,
  input  logic         sil,
  input  logic         sir,
  output logic [N-1:0] Q,
  output logic [N-1:0] Qnot,
  output logic         sol,
  output logic         sor,
  output logic         co
`ifdef UNIV_REG_PARITY_EN
  ,
  output logic         par
`endif
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  logic [N-1:0] q_nxt;
  logic         co_nxt;
  logic [N:0]   inc_w;
  logic [N:0]   dec_w;

  // Top bit of the widened sum/difference is the carry-out / borrow.
  assign inc_w = {1'b0, Q} + ONE;
  assign dec_w = {1'b0, Q} - ONE;

  assign Qnot = ~Q;
  assign sol  = Q[N-1];
  assign sor  = Q[0];

  always_comb begin
    q_nxt  = Q;
    co_nxt = 1'b0;
    if (!pre) begin
      q_nxt = PRE_VAL;
    end else if (en) begin
      case (mode)
        MODE_HOLD: q_nxt = Q;
        MODE_LOAD: q_nxt = D;
        MODE_SHL:  q_nxt = {Q[N-2:0], sil};
        MODE_SHR:  q_nxt = {sir, Q[N-1:1]};
        MODE_ROL:  q_nxt = {Q[N-2:0], Q[N-1]};
        MODE_ROR:  q_nxt = {Q[0], Q[N-1:1]};
        MODE_INC: begin
          q_nxt  = inc_w[N-1:0];
          co_nxt = inc_w[N];
        end
        MODE_DEC: begin
          q_nxt  = dec_w[N-1:0];
          co_nxt = dec_w[N];
        end
        default:   q_nxt = Q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      Q  <= '0;
      co <= 1'b0;
    end else begin
      Q  <= q_nxt;
      co <= co_nxt;
    end
  end

`ifdef UNIV_REG_PARITY_EN
  // Parity of the value being loaded, so par is aligned with Q every cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      par <= 1'b0;
    end else begin
      par <= ^q_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_univ_reg_n.sv
// Bench for univ_reg_n (N=8): directed plan steps followed by randomized cycles against an integer reference model.
module tb_univ_reg_n;

  localparam int N = 8;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         clr;
  logic         pre;
  logic         en;
  logic [2:0]   mode;
  logic [N-1:0] D;
  logic         sil;
  logic         sir;
  logic [N-1:0] Q;
  logic [N-1:0] Qnot;
  logic         sol;
  logic         sor;
  logic         co;
`ifdef UNIV_REG_PARITY_EN
  logic         par;
`endif

  int compared   = 0;
  int mismatched = 0;
  int m_q  = 0;
  int m_co = 0;

  univ_reg_n #(.N(N)) dut (
    .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode), .D(D),
    .sil(sil), .sir(sir), .Q(Q), .Qnot(Qnot), .sol(sol), .sor(sor), .co(co)
`ifdef UNIV_REG_PARITY_EN
    , .par(par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Q"},    Q,    m_q);
    chk({tag, ".Qnot"}, Qnot, (M - 1) - m_q);
    chk({tag, ".sol"},  sol,  m_q / (M / 2));
    chk({tag, ".sor"},  sor,  m_q % 2);
    chk({tag, ".co"},   co,   m_co);
`ifdef UNIV_REG_PARITY_EN
    chk({tag, ".par"},  par,  $countones(m_q) % 2);
`endif
  endtask

  // Reference behaviour of one rising edge with clr high, in plain integer arithmetic.
  task automatic model_edge();
    int nq;
    nq   = m_q;
    m_co = 0;
    if (pre === 1'b0) begin
      nq = M - 1;
    end else if (en === 1'b1) begin
      case (int'(mode))
        1: nq = int'(D);
        2: nq = (m_q * 2) % M + int'(sil);
        3: nq = int'(sir) * (M / 2) + m_q / 2;
        4: nq = (m_q * 2) % M + m_q / (M / 2);
        5: nq = (m_q % 2) * (M / 2) + m_q / 2;
        6: begin m_co = (m_q == M - 1); nq = (m_q + 1) % M; end
        7: begin m_co = (m_q == 0);     nq = (m_q + M - 1) % M; end
        default: nq = m_q;
      endcase
    end
    m_q = nq;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic p, input logic e, input logic [2:0] md, input logic [N-1:0] d);
    pre  = p;
    en   = e;
    mode = md;
    D    = d;
  endtask

  task automatic async_clear(input string tag);
    clr = 1'b0;
    #1;
    m_q  = 0;
    m_co = 0;
    check_all(tag);
    #1;
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0; sil = 1'b0; sir = 1'b0;
    drive(1'b1, 1'b0, 3'd0, '0);
    #1;
    check_all("reset_t0");
    @(posedge clk); #1;
    check_all("reset_held");
    clr = 1'b1;

    // Reset and complement
    drive(1'b1, 1'b1, 3'd1, 8'hA5); step("load_a5");
    async_clear("clr_async");
    drive(1'b1, 1'b1, 3'd1, 8'h3C); step("load_3c");
    chk("plan_qnot_c3", Qnot, 8'hC3);

    // Preset priority over en and mode
    drive(1'b0, 1'b0, 3'd6, 8'h00); step("preset_dis");
    drive(1'b0, 1'b1, 3'd1, 8'h12); step("preset_load");
    chk("plan_preset_ff", Q, 8'hFF);

    // Shift / rotate / serial out
    drive(1'b1, 1'b1, 3'd1, 8'h81); step("load_81");
    chk("sol_before_shl", sol, 1'b1);
    sil = 1'b0; drive(1'b1, 1'b1, 3'd2, 8'h00); step("shl");
    chk("plan_shl_02", Q, 8'h02);
    sir = 1'b1; drive(1'b1, 1'b1, 3'd3, 8'h00); step("shr");
    chk("plan_shr_81", Q, 8'h81);
    drive(1'b1, 1'b1, 3'd4, 8'h00); step("rol");
    chk("plan_rol_03", Q, 8'h03);
    drive(1'b1, 1'b1, 3'd5, 8'h00); step("ror");
    chk("plan_ror_81", Q, 8'h81);

    // Counter wrap in both directions
    drive(1'b1, 1'b1, 3'd1, 8'hFE); step("load_fe");
    drive(1'b1, 1'b1, 3'd6, 8'h00); step("inc_ff");
    step("inc_wrap");
    chk("plan_inc_co", co, 1'b1);
    drive(1'b1, 1'b1, 3'd0, 8'h00); step("hold_co0");
    drive(1'b1, 1'b1, 3'd1, 8'h00); step("load_00");
    drive(1'b1, 1'b1, 3'd7, 8'h00); step("dec_wrap");
    chk("plan_dec_co", co, 1'b1);

    // Enable freeze and mid-run clear
    drive(1'b1, 1'b1, 3'd1, 8'h10); step("load_10");
    drive(1'b1, 1'b1, 3'd6, 8'h00); step("run_inc1"); step("run_inc2");
    en = 1'b0; step("frozen1"); step("frozen2");
    chk("plan_frozen_12", Q, 8'h12);
    en = 1'b1; step("run_inc3");
    async_clear("clr_midrun");
    step("inc_after_clr");
    chk("plan_after_clr_01", Q, 8'h01);

    // Randomized operation with occasional presets, disables and clears
    for (int i = 0; i < 500; i++) begin
      pre  = ($urandom_range(0, 15) != 0);
      en   = ($urandom_range(0, 7) != 0);
      mode = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       D = '0;
        1:       D = '1;
        default: D = N'($urandom);
      endcase
      sil = 1'($urandom);
      sir = 1'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        async_clear("rand_clr");
      end else begin
        step("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
